// File: rtl/router_pkg.sv
// Shared packet layout, mesh size and source FSM encoding for the terminal-side router blocks.
package router_pkg;

    localparam int ROWS    = 4;
    localparam int COLUMS  = 4;
    localparam int N_TERMS = ROWS * 2 + COLUMS * 2;

    localparam int PCK_SZ  = 40;
    localparam int ID_W    = 6;
    localparam int DST_MSB = 31;
    localparam int DST_LSB = 26;
    localparam int SRC_MSB = 25;
    localparam int SRC_LSB = 20;
    localparam int PAY_W   = 20;

    typedef logic [PCK_SZ-1:0] pkt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        STALLED = 2'd2
    } src_state_e;

    // Jump field [39:32] is left at zero; the router fills it as the packet travels.
    function automatic pkt_t mk_pkt(input logic [ID_W-1:0]  dst,
                                    input logic [ID_W-1:0]  src,
                                    input logic [PAY_W-1:0] pay);
        pkt_t p;
        p                  = '0;
        p[DST_MSB:DST_LSB] = dst;
        p[SRC_MSB:SRC_LSB] = src;
        p[PAY_W-1:0]       = pay;
        return p;
    endfunction

endpackage

// File: rtl/router_fwft_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO is accepted when a read retires the head in the same cycle.
module router_fwft_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; empty/count gate every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= din;
    end

    assign dout = empty ? '0 : mem[rptr];

endmodule

// File: rtl/router_term_src.sv
// Terminal packet source: builds packets, queues them in a FWFT FIFO and drives the pndng/pop handshake.
module router_term_src #(
    parameter int PCK_SZ  = 40,
    parameter int DEPTH   = 8,
    parameter int SRC_ID  = 0,
    parameter int TIMEOUT = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [5:0]                   wr_dst,
    input  logic [router_pkg::PAY_W-1:0] wr_payload,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output logic [PCK_SZ-1:0]            data_out_i_in,
    output logic                         pndng_i_in,
    input  logic                         popin,
    output logic [15:0]                  drop_cnt,
    output logic                         bad_dst,
    output logic                         pop_err,
    output logic                         stall_timeout
);

    import router_pkg::*;

    localparam int               CW         = $clog2(DEPTH) + 1;
    localparam int               TCW        = $clog2(TIMEOUT);
    localparam logic [ID_W-1:0]  MY_ID      = ID_W'(SRC_ID);
    localparam logic [ID_W-1:0]  TERMS      = ID_W'(N_TERMS);
    localparam logic [TCW-1:0]   STALL_LAST = TCW'(TIMEOUT - 2);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_WAIT    = WAIT;
    localparam logic [1:0] ST_STALLED = STALLED;

    logic           dst_ok;
    logic           pop;
    logic           wr_acc;
    logic           wr_drop;
    logic           empty;
    logic           drains;
    pkt_t           pkt;
    logic [1:0]     state;
    logic [TCW-1:0] stall_cnt;

    assign dst_ok     = (wr_dst < TERMS) && (wr_dst != MY_ID);
    assign pop        = popin && pndng_i_in;
    assign wr_acc     = wr_en && dst_ok && (!full || pop);
    assign wr_drop    = wr_en && !wr_acc;
    assign pndng_i_in = !empty;
    assign pkt        = mk_pkt(wr_dst, MY_ID, wr_payload);

    // True when the FIFO will hold nothing after this edge.
    assign drains = !wr_acc && ((count == CW'(0)) || (count == CW'(1) && pop));

    router_fwft_fifo #(
        .W     (PCK_SZ),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_acc),
        .rd    (pop),
        .din   (pkt),
        .dout  (data_out_i_in),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
            bad_dst  <= 1'b0;
            pop_err  <= 1'b0;
        end else begin
            if (wr_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            if (wr_en && !dst_ok)                bad_dst  <= 1'b1;
            if (popin && !pndng_i_in)            pop_err  <= 1'b1;
        end
    end

    // A pop restarts the stall window; STALLED only leaves on a pop and never clears the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pndng_i_in) begin
                        state     <= ST_WAIT;
                        stall_cnt <= '0;
                    end
                end
                ST_WAIT, ST_STALLED: begin
                    if (drains) begin
                        state     <= ST_IDLE;
                        stall_cnt <= '0;
                    end else if (pop) begin
                        state     <= ST_WAIT;
                        stall_cnt <= '0;
                    end else if (state == ST_WAIT) begin
                        if (stall_cnt == STALL_LAST) begin
                            state         <= ST_STALLED;
                            stall_timeout <= 1'b1;
                        end
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_term_src.sv
// Self-checking bench for router_term_src: table vectors, directed corner sequences and a randomized queue model.
module tb_router_term_src;

    localparam int SRC     = 2;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 128;
    localparam int NT      = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_dst = '0;
    logic [19:0] wr_payload = '0;
    logic        popin = 1'b0;
    logic        full;
    logic [3:0]  count;
    logic [39:0] data_out_i_in;
    logic        pndng_i_in;
    logic [15:0] drop_cnt;
    logic        bad_dst;
    logic        pop_err;
    logic        stall_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [39:0] mq[$];
    int          m_drop;
    bit          m_bad, m_perr, m_stall;
    int          m_age;

    router_term_src #(
        .PCK_SZ  (40),
        .DEPTH   (DEPTH),
        .SRC_ID  (SRC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_dst        (wr_dst),
        .wr_payload    (wr_payload),
        .full          (full),
        .count         (count),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .popin         (popin),
        .drop_cnt      (drop_cnt),
        .bad_dst       (bad_dst),
        .pop_err       (pop_err),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] mk(input logic [5:0] dst, input logic [19:0] pay);
        logic [5:0] s;
        s = 6'(SRC);
        return {8'h00, dst, s, pay};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit we, input logic [5:0] dst, input logic [19:0] pay, input bit pop);
        wr_en      = we;
        wr_dst     = dst;
        wr_payload = pay;
        popin      = pop;
    endtask

    task automatic model_clear();
        mq.delete();
        m_drop  = 0;
        m_bad   = 0;
        m_perr  = 0;
        m_stall = 0;
        m_age   = -1;
    endtask

    // Advance one clock: update the model from the current inputs, then sample after the edge.
    task automatic tick();
        int n;
        bit ok, pop_m, acc;
        n     = mq.size();
        ok    = (int'(wr_dst) < NT) && (int'(wr_dst) != SRC);
        pop_m = popin && (n > 0);
        acc   = wr_en && ok && (n < DEPTH || pop_m);
        if (wr_en && !acc && m_drop < 65535) m_drop++;
        if (wr_en && !ok) m_bad = 1;
        if (popin && n == 0) m_perr = 1;
        if (pop_m) void'(mq.pop_front());
        if (acc) mq.push_back(mk(wr_dst, wr_payload));
        if (m_age < 0) begin
            if (n > 0) m_age = 0;
        end else if (mq.size() == 0) begin
            m_age = -1;
        end else if (pop_m) begin
            m_age = 0;
        end else if (!m_stall) begin
            m_age++;
            if (m_age == TIMEOUT - 1) m_stall = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        logic [39:0] head;
        head = (mq.size() > 0) ? mq[0] : 40'h0;
        check({tag, ".count"}, 64'(count), 64'(mq.size()));
        check({tag, ".full"},  64'(full), 64'(mq.size() == DEPTH));
        check({tag, ".pndng"}, 64'(pndng_i_in), 64'(mq.size() != 0));
        check({tag, ".data"},  64'(data_out_i_in), 64'(head));
        check({tag, ".drop"},  64'(drop_cnt), 64'(m_drop));
        check({tag, ".bad_dst"}, 64'(bad_dst), 64'(m_bad));
        check({tag, ".pop_err"}, 64'(pop_err), 64'(m_perr));
        check({tag, ".stall"}, 64'(stall_timeout), 64'(m_stall));
    endtask

    task automatic do_reset();
        drive(0, 6'd0, 20'h0, 0);
        reset = 1'b1;
        #1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [5:0]  dst;
        logic [19:0] pay;
        bit          pop;
        int          e_count;
        bit          e_pndng;
        int          e_drop;
        bit          e_bad;
        bit          e_perr;
        logic [39:0] e_head;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{1, 6'd5,  20'hABCDE, 0, 1, 1, 0, 0, 0, 40'h00_142A_BCDE};
        vt[1] = '{0, 6'd0,  20'h0,     1, 0, 0, 0, 0, 0, 40'h0};
        vt[2] = '{0, 6'd0,  20'h0,     1, 0, 0, 0, 0, 1, 40'h0};
        vt[3] = '{1, 6'd16, 20'h11111, 0, 0, 0, 1, 1, 1, 40'h0};
        vt[4] = '{1, 6'd2,  20'h22222, 0, 0, 0, 2, 1, 1, 40'h0};
        vt[5] = '{1, 6'd15, 20'h00001, 0, 1, 1, 2, 1, 1, mk(6'd15, 20'h00001)};
        vt[6] = '{1, 6'd0,  20'hFFFFF, 1, 1, 1, 2, 1, 1, mk(6'd0, 20'hFFFFF)};
        vt[7] = '{0, 6'd0,  20'h0,     1, 0, 0, 2, 1, 1, 40'h0};
        vt[8] = '{1, 6'd63, 20'h0,     0, 0, 0, 3, 1, 1, 40'h0};

        model_clear();
        do_reset();

        // Reset state
        check("rst.count", 64'(count), 64'd0);
        check("rst.pndng", 64'(pndng_i_in), 64'd0);
        check("rst.data",  64'(data_out_i_in), 64'd0);
        check("rst.full",  64'(full), 64'd0);
        check("rst.drop",  64'(drop_cnt), 64'd0);
        check("rst.flags", 64'({bad_dst, pop_err, stall_timeout}), 64'd0);

        // Table vectors: basic write/pop, pop-on-empty, bad destinations
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].we, vt[i].dst, vt[i].pay, vt[i].pop);
            tick();
            check($sformatf("vec%0d.count", i), 64'(count), 64'(vt[i].e_count));
            check($sformatf("vec%0d.pndng", i), 64'(pndng_i_in), 64'(vt[i].e_pndng));
            check($sformatf("vec%0d.data", i),  64'(data_out_i_in), 64'(vt[i].e_head));
            check($sformatf("vec%0d.drop", i),  64'(drop_cnt), 64'(vt[i].e_drop));
            check($sformatf("vec%0d.bad", i),   64'(bad_dst), 64'(vt[i].e_bad));
            check($sformatf("vec%0d.perr", i),  64'(pop_err), 64'(vt[i].e_perr));
        end
        drive(0, 6'd0, 20'h0, 0);

        // Fill to full, overflow drop, write+pop while full, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 6'(i + 3), 20'($urandom), 0);
            tick();
        end
        check("fill.full",  64'(full), 64'd1);
        check("fill.count", 64'(count), 64'd8);
        drive(1, 6'd4, 20'h12345, 0);
        tick();
        check("ovf.drop", 64'(drop_cnt), 64'd4);
        check("ovf.count", 64'(count), 64'd8);
        drive(1, 6'd9, 20'h55AA5, 1);
        tick();
        check("fullwp.count", 64'(count), 64'd8);
        compare_all("fullwp");
        drive(0, 6'd0, 20'h0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            compare_all($sformatf("drain%0d", i));
            tick();
        end
        check("drain.pndng", 64'(pndng_i_in), 64'd0);
        drive(0, 6'd0, 20'h0, 0);

        // Stall timeout boundary: 127 pending cycles is not enough, 128 is
        do_reset();
        drive(1, 6'd7, 20'h0BEEF, 0);
        tick();
        drive(0, 6'd0, 20'h0, 0);
        for (int i = 1; i < TIMEOUT; i++) tick();
        check("stall.127", 64'(stall_timeout), 64'd0);
        tick();
        check("stall.128", 64'(stall_timeout), 64'd1);
        drive(0, 6'd0, 20'h0, 1);
        tick();
        drive(0, 6'd0, 20'h0, 0);
        check("stall.pop_pndng", 64'(pndng_i_in), 64'd0);
        check("stall.sticky",    64'(stall_timeout), 64'd1);
        compare_all("stall");

        // Pop on empty, then randomized traffic across pointer wrap
        do_reset();
        drive(0, 6'd0, 20'h0, 1);
        tick();
        check("perr.flag",  64'(pop_err), 64'd1);
        check("perr.count", 64'(count), 64'd0);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 6'($urandom_range(0, 17)), 20'($urandom), ($urandom % 2) == 1);
            tick();
            compare_all("rnd");
        end
        drive(0, 6'd0, 20'h0, 0);

        // Drop counter saturation
        do_reset();
        drive(1, 6'd63, 20'h0, 0);
        for (int i = 0; i < 65540; i++) tick();
        drive(0, 6'd0, 20'h0, 0);
        check("sat.drop", 64'(drop_cnt), 64'hFFFF);
        compare_all("sat");

        // Async reset with packets queued
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 6'(i + 8), 20'(i * 3 + 1), 0);
            tick();
        end
        drive(0, 6'd0, 20'h0, 0);
        check("flush.pre", 64'(count), 64'd5);
        #2;
        reset = 1'b1;
        #1;
        check("flush.count", 64'(count), 64'd0);
        check("flush.pndng", 64'(pndng_i_in), 64'd0);
        check("flush.data",  64'(data_out_i_in), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            compare_all($sformatf("post%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
